mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mux4_rr_arbiter: 4-way round-robin arbiter with bounded grant hold.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       last_i,
  output logic [3:0] grant_o,
  output logic [1:0] select_o,
  output logic       valid_o
);

  localparam logic       ST_IDLE   = 1'b0;
  localparam logic       ST_GRANT  = 1'b1;
  localparam logic       C_HOLD_EN = (MAX_HOLD != 0);
  localparam logic [7:0] C_HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  logic       state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] select_q, select_d;

  logic       release_w;
  logic [1:0] arb_ptr_w;
  logic [1:0] win_idx_w;
  logic       win_found_w;

  // First requester at or after the given pointer, wrapping mod 4.
  function automatic logic [2:0] find_winner(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  always_comb begin
    release_w = 1'b0;
    if (state_q == ST_GRANT) begin
      release_w = !req_i[select_q] || last_i ||
                  (C_HOLD_EN && (cnt_q == C_HOLD_LAST));
    end
  end

  // On release the departing owner drops to lowest priority immediately.
  assign arb_ptr_w = release_w ? (select_q + 2'd1) : ptr_q;
  assign {win_found_w, win_idx_w} = find_winner(req_i, arb_ptr_w);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    select_d = select_q;
    if (state_q == ST_GRANT && !release_w) begin
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      ptr_d = arb_ptr_w;
      if (win_found_w) begin
        state_d  = ST_GRANT;
        grant_d  = 4'b0001 << win_idx_w;
        select_d = win_idx_w;
        cnt_d    = 8'd0;
      end else begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        cnt_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= 8'd0;
      grant_q  <= 4'b0000;
      select_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      select_q <= select_d;
    end
  end

  assign grant_o  = grant_q;
  assign select_o = select_q;
  assign valid_o  = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mux4_rr_arbiter: checks two arbiter instances against a model.      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       last;
  logic [3:0] req;
  logic [3:0] g8, g0;
  logic [1:0] s8, s0;
  logic       v8, v0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last),
    .grant_o(g8), .select_o(s8), .valid_o(v8)
  );

  mux4_rr_arbiter #(.MAX_HOLD(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .last_i(last),
    .grant_o(g0), .select_o(s0), .valid_o(v0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state per instance: owner -1 means idle.
  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_sel[2];
  int hold[2] = '{8, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model(input int i);
    bit rel;
    if (rst) begin
      m_owner[i] = -1; m_ptr[i] = 0; m_cnt[i] = 0; m_sel[i] = 0;
    end else if (m_owner[i] < 0) begin
      if (req != 4'b0) begin
        m_owner[i] = pick(req, m_ptr[i]);
        m_sel[i]   = m_owner[i];
        m_cnt[i]   = 0;
      end
    end else begin
      rel = !req[m_owner[i]] || last || (hold[i] != 0 && m_cnt[i] == hold[i] - 1);
      if (!rel) begin
        m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
      end else begin
        m_ptr[i] = (m_owner[i] + 1) % 4;
        m_owner[i] = pick(req, m_ptr[i]);
        m_cnt[i] = 0;
        if (m_owner[i] >= 0) m_sel[i] = m_owner[i];
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(input int i);
    return (m_owner[i] < 0) ? 4'b0000 : (4'b0001 << m_owner[i]);
  endfunction

  task automatic step(input logic [3:0] r, input logic l, input logic rs);
    req = r; last = l; rst = rs;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    chk("grant_h8",  32'(g8), 32'(exp_grant(0)));
    chk("select_h8", 32'(s8), 32'(m_sel[0]));
    chk("valid_h8",  32'(v8), 32'(m_owner[0] >= 0));
    chk("grant_h0",  32'(g0), 32'(exp_grant(1)));
    chk("select_h0", 32'(s0), 32'(m_sel[1]));
    chk("valid_h0",  32'(v0), 32'(m_owner[1] >= 0));
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b0, 1'b1);
  endtask

  logic [3:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr;

  initial begin
    req = 4'b0; last = 1'b0; rst = 1'b1;

    // Reset with all requesting, then first grant one cycle after release.
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    chk("rst_grant", 32'(g8), 32'h0);
    chk("rst_sel",   32'(s8), 32'h0);
    chk("rst_valid", 32'(v8), 32'h0);
    step(4'b1111, 1'b0, 1'b0);
    chk("first_grant", 32'(g8), 32'h1);

    // Single hold then drop: select must hold its value.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("hold_grant", 32'(g8), 32'h4);
    end
    step(4'b0000, 1'b0, 1'b0);
    chk("drop_grant", 32'(g8), 32'h0);
    chk("drop_sel",   32'(s8), 32'h2);

    // Rotation with last every cycle, no bubbles.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("rotate", 32'(g8), 32'(rot_exp[c]));
    end

    // Hold limit of 8 vs unlimited hold.
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      step(4'b0011, 1'b0, 1'b0);
      if (c <= 8)       chk("limit_r0", 32'(g8), 32'h1);
      else if (c <= 16) chk("limit_r1", 32'(g8), 32'h2);
      else              chk("limit_r0b", 32'(g8), 32'h1);
    end
    do_reset();
    for (int c = 1; c <= 100; c++) begin
      step(4'b0011, 1'b0, 1'b0);
      chk("nolimit", 32'(g0), 32'h1);
    end

    // Pointer wrap from owner 3.
    do_reset();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    chk("wrap_grant", 32'(g8), 32'h1);
    chk("wrap_sel",   32'(s8), 32'h0);

    // Sole requester released by the hold limit is re-granted without a gap.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("sole_valid", 32'(v8), 32'h1);
    end

    // Reset in the middle of a grant.
    do_reset();
    for (int c = 1; c <= 2; c++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    chk("midrst_grant", 32'(g8), 32'h0);
    step(4'b0010, 1'b0, 1'b0);
    chk("postrst_grant", 32'(g8), 32'h2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rr = 4'($urandom);
      if ($urandom_range(0, 7) == 0) rr = 4'b0000;
      step(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
